led_fader: RTL and testbench

LED output stage of the gb3 RV32I SoC. It sits downstream of the data memory's memory-mapped LED register, between that register and the board's `led_o` pins. Each of the 8 on/off bits is turned into a PWM-driven channel that ramps brightness up or down at a fixed rate instead of switching hard. It runs on the ungated oscillator clock, not on the stall-gated processor clock.

---
 rtl/led_fader.sv | 64 ++++++
 tb/tb_led_fader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: turns 8 on/off LED bits into PWM channels that ramp brightness at a fixed rate
// Ports: clk_i oscillator clock; rst_i synchronous active-high reset; led_i target on/off per
//        channel; en_i global enable (0 = all dark); led_o registered pin drive (polarity per
//        ACTIVE_LOW); busy_o high while any channel's duty differs from its target.
module led_fader #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 46875,
    parameter int FADE_STEP  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] led_i,
    input  logic       en_i,
    output logic [7:0] led_o,
    output logic       busy_o
);
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam int                  SW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0]       LAST = SW'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP = (PWM_BITS + 1)'(FADE_STEP);
    localparam logic [7:0]          DARK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [7:0]          led_q, lit, busy;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       step_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] duty     [8];
    logic [PWM_BITS-1:0] duty_nxt [8];
    logic [PWM_BITS:0]   up       [8];

    assign step_tick = step_cnt == LAST;
    assign busy_o    = |busy;

    // Saturating ramp: the increment carries one extra bit so overflow clamps to MAX
    // instead of wrapping; the decrement floors at zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            up[i]       = {1'b0, duty[i]} + STEP;
            duty_nxt[i] = led_q[i] ? (up[i] > {1'b0, MAX} ? MAX : up[i][PWM_BITS-1:0])
                                   : ({1'b0, duty[i]} > STEP ? duty[i] - STEP[PWM_BITS-1:0] : '0);
            // duty == MAX stays lit through the pwm_cnt == MAX slot too
            lit[i]      = en_i & ((duty[i] == MAX) | (duty[i] > pwm_cnt));
            busy[i]     = duty[i] != (led_q[i] ? MAX : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q    <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            led_o    <= DARK;
            for (int i = 0; i < 8; i++) duty[i] <= '0;
        end else begin
            led_q    <= led_i;
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            led_o    <= lit ^ DARK;
            if (step_tick)
                for (int i = 0; i < 8; i++) duty[i] <= duty_nxt[i];
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: three led_fader instances (step 1/div 4, step 4/div 4, step 1/div 64) checked
// every cycle against a cycle-level arithmetic model, plus directed fade/PWM/enable/reset checks.
module tb_led_fader;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b1;
    logic [7:0] led_i = 8'h00;
    logic [7:0] led_a, led_b, led_c;
    logic       busy_a, busy_b, busy_c;

    int checks = 0;
    int failures = 0;

    localparam int SD[3] = '{4, 4, 64};
    localparam int FS[3] = '{1, 4, 1};
    localparam int UP4[5] = '{4, 8, 12, 15, 15};
    localparam int DN4[5] = '{11, 7, 3, 0, 0};

    int         m_duty [3][8];
    int         m_step [3];
    int         m_pwm;
    logic [7:0] m_q;
    logic [7:0] m_o [3];

    led_fader #(.PWM_BITS(4), .STEP_DIV(4), .FADE_STEP(1), .ACTIVE_LOW(1)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .led_i(led_i), .en_i(en_i), .led_o(led_a), .busy_o(busy_a));
    led_fader #(.PWM_BITS(4), .STEP_DIV(4), .FADE_STEP(4), .ACTIVE_LOW(1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .led_i(led_i), .en_i(en_i), .led_o(led_b), .busy_o(busy_b));
    led_fader #(.PWM_BITS(4), .STEP_DIV(64), .FADE_STEP(1), .ACTIVE_LOW(1)) dut_c (
        .clk_i(clk), .rst_i(rst_i), .led_i(led_i), .en_i(en_i), .led_o(led_c), .busy_o(busy_c));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic busy_exp(input int k);
        for (int i = 0; i < 8; i++)
            if (m_duty[k][i] != (m_q[i] ? 15 : 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Model of one clock edge, from the values present just before the edge.
    task automatic model_step();
        if (rst_i) begin
            m_pwm = 0;
            m_q = 8'h00;
            for (int k = 0; k < 3; k++) begin
                m_step[k] = 0;
                m_o[k] = 8'hFF;
                for (int i = 0; i < 8; i++) m_duty[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 8; i++)
                    m_o[k][i] = !(en_i && (m_duty[k][i] == 15 || m_duty[k][i] > m_pwm));
                if (m_step[k] == SD[k] - 1)
                    for (int i = 0; i < 8; i++)
                        m_duty[k][i] = m_q[i] ? ((m_duty[k][i] + FS[k] > 15) ? 15 : m_duty[k][i] + FS[k])
                                              : ((m_duty[k][i] - FS[k] < 0) ? 0 : m_duty[k][i] - FS[k]);
                m_step[k] = (m_step[k] + 1) % SD[k];
            end
            m_pwm = (m_pwm + 1) % 16;
            m_q = led_i;
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("led_a", led_a, m_o[0]);
            chk("led_b", led_b, m_o[1]);
            chk("led_c", led_c, m_o[2]);
            chk("busy_a", busy_a, busy_exp(0));
            chk("busy_b", busy_b, busy_exp(1));
            chk("busy_c", busy_c, busy_exp(2));
            chk("duty_a0", dut_a.duty[0], m_duty[0][0]);
            chk("duty_b0", dut_b.duty[0], m_duty[1][0]);
            chk("duty_c0", dut_c.duty[0], m_duty[2][0]);
        end
    endtask

    task automatic wait_tick(input int k, input string tag);
        int n = 0;
        do begin cyc(); n++; end while (m_step[k] != 0 && n < 200);
        chk(tag, m_step[k], 0);
    endtask

    initial begin
        int n;
        int lows;
        // 1: reset and idle
        cyc(3);
        chk("rst_led", led_a, 8'hFF);
        chk("rst_busy", busy_a, 1'b0);
        rst_i = 1'b0;
        cyc(100);
        chk("idle_led", led_a, 8'hFF);
        // 2: fade up channel 0 and hold
        led_i = 8'h01;
        cyc();
        chk("busy_rise", busy_a, 1'b1);
        cyc(70);
        chk("hold_led", led_a, 8'hFE);
        chk("hold_busy", busy_a, 1'b0);
        chk("hold_duty", dut_a.duty[0], 15);
        // 3: PWM duty of 5 on the slow instance, observed between ticks
        n = 0;
        while (!(m_duty[2][0] == 5 && m_step[2] == 0) && n < 2000) begin cyc(); n++; end
        chk("c_duty5", dut_c.duty[0], 5);
        cyc();
        lows = 0;
        for (int j = 0; j < 16; j++) begin
            cyc();
            if (led_c[0] == 1'b0) lows++;
        end
        chk("pwm_lows", lows, 5);
        // 4: reversal mid-fade
        rst_i = 1'b1;
        cyc();
        chk("rst_mid_led", led_a, 8'hFF);
        rst_i = 1'b0;
        led_i = 8'h01;
        n = 0;
        while (m_duty[0][0] != 7 && n < 200) begin cyc(); n++; end
        chk("rev_peak", dut_a.duty[0], 7);
        led_i = 8'h00;
        cyc(60);
        chk("rev_led", led_a, 8'hFF);
        chk("rev_busy", busy_a, 1'b0);
        chk("rev_duty", dut_a.duty[0], 0);
        // 5: FADE_STEP=4 saturation both ways
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        led_i = 8'hFF;
        for (int t = 0; t < 5; t++) begin
            wait_tick(1, "up_tick");
            chk("fs4_up", dut_b.duty[0], UP4[t]);
        end
        led_i = 8'h00;
        for (int t = 0; t < 5; t++) begin
            wait_tick(1, "dn_tick");
            chk("fs4_dn", dut_b.duty[0], DN4[t]);
        end
        // 6: enable and reset mid-fade
        led_i = 8'hFF;
        cyc(80);
        chk("all_on", led_a, 8'h00);
        en_i = 1'b0;
        cyc();
        chk("en_off", led_a, 8'hFF);
        en_i = 1'b1;
        cyc();
        chk("en_on", led_a, 8'h00);
        led_i = 8'h00;
        cyc(10);
        rst_i = 1'b1;
        cyc();
        chk("rst_fade_led", led_a, 8'hFF);
        chk("rst_fade_busy", busy_a, 1'b0);
        for (int i = 0; i < 8; i++) chk("rst_fade_duty", dut_a.duty[i], 0);
        rst_i = 1'b0;
        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) led_i = 8'($urandom);
            if ($urandom_range(0, 29) == 0) en_i = ~en_i;
            rst_i = ($urandom_range(0, 499) == 0);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
